ripple_count_sampler: RTL and testbench
=======================================

Name: ripple_count_sampler

Overview:
- Downstream consumer of the 8-bit ripple counter output Q.
- Ripple outputs settle bit-by-bit and are not synchronous to the system clock. This block reads the raw count with a consecutive-sample stability check and presents a clean, registered snapshot.
- Output uses a valid/ready handshake.
- Each snapshot is tagged with a wrap indication, a threshold-hit indication and a stability-error indication.

Parameters:
- WIDTH, 8: counter width; must match the upstream counter.
- MAX_RETRY, 4: maximum mismatching comparisons before a snapshot is forced out. Legal range 1..15.

Ports:
- clk  input  1  system clock; all flops on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- count_in  input  WIDTH  raw ripple counter value; may be mid-ripple.
- sample_req  input  1  capture request; sampled only in IDLE.
- threshold  input  WIDTH  compare value; sampled when a snapshot is loaded.
- sample_ready  input  1  downstream ready.
- sample_valid  output  1  snapshot available.
- sample_data  output  WIDTH  snapshot value.
- wrap_flag  output  1  snapshot is numerically below the last accepted snapshot.
- thresh_hit  output  1  sample_data >= threshold (unsigned).
- stab_err  output  1  snapshot forced after MAX_RETRY mismatches.

Behaviour:

Reset (reset=0, async):
- state=IDLE.
- All outputs 0.
- samp_a, samp_b, retry_cnt and last_acc cleared to 0.
- Reset asserted mid-SAMPLE or mid-PRESENT abandons the snapshot immediately. After release: IDLE, sample_valid=0, no stale data.

Sampling pipe (free-running in every state):
- samp_a <= count_in
- samp_b <= samp_a
- "stable" = (samp_a == samp_b).

FSM:
- IDLE: sample_valid=0.
  - sample_req=1 -> SAMPLE, retry_cnt<=0.
- SAMPLE:
  - If stable: load sample_data<=samp_a, stab_err<=0 -> PRESENT.
  - Else if retry_cnt==MAX_RETRY-1: load sample_data<=samp_a, stab_err<=1 -> PRESENT.
  - Else retry_cnt<=retry_cnt+1, stay in SAMPLE.
- PRESENT: sample_valid=1.
  - sample_data, wrap_flag, thresh_hit and stab_err are held constant while sample_valid=1 and sample_ready=0.
  - On sample_valid & sample_ready: last_acc<=sample_data, sample_valid deasserts next cycle -> IDLE.

Flag computation (on load, registered with sample_data):
- wrap_flag = (samp_a < last_acc). last_acc updates only on a completed transfer.
- thresh_hit = (samp_a >= threshold), unsigned.
- threshold=0 always hits. threshold=2^WIDTH-1 hits only at the all-ones value.

Latency:
- With count_in constant for at least 2 cycles before the request, sample_valid rises on the 2nd rising edge after the edge that sampled sample_req=1.
- Worst case (never stable): MAX_RETRY+1 edges.

Boundary conditions:
- sample_req held high is treated as back-to-back requests: one snapshot per IDLE visit, minimum 3 cycles apart.
- sample_req in SAMPLE or PRESENT is ignored, not queued.
- sample_ready may be high before sample_valid; the transfer happens in the first PRESENT cycle.
- Count wrap 255->0 between accepted snapshots gives wrap_flag=1.
- Equal consecutive snapshots give wrap_flag=0.
- First snapshot after reset: last_acc=0, so wrap_flag=0.
- MAX_RETRY=1: a single mismatch forces the snapshot out.
- No combinational path from any input to any output.

Test Plan:
- count_in=8'h2A constant, sample_req pulse at edge 0, sample_ready=1 -> sample_valid=1 at edge 2, sample_data=8'h2A, stab_err=0, wrap_flag=0. IDLE at edge 3.
- Back-pressure: sample_ready=0 for 5 cycles with count_in changing -> sample_data and all flags hold. Transfer completes on the first ready=1 cycle.
- Wrap: accept snapshot 8'hFE, then count_in=8'h03, request -> wrap_flag=1. Next snapshot 8'h07 -> wrap_flag=0.
- Threshold: threshold=8'd100; snapshots 99, 100, 255 -> thresh_hit 0, 1, 1. Changing threshold during PRESENT does not change thresh_hit.
- Instability: count_in toggles every cycle, MAX_RETRY=4 -> sample_valid at edge 5, stab_err=1, sample_data equals the samp_a value at the forcing edge.
- Reset: assert reset=0 during SAMPLE and again during PRESENT -> outputs 0 immediately, asynchronously. After release, no sample_valid without a new sample_req.

Source files
------------

// File: rtl/ripple_count_sampler_if.sv
// Snapshot output channel of ripple_count_sampler: valid/ready handshake plus
// the snapshot value and its tag flags.
interface ripple_count_sampler_if #(
  parameter int WIDTH = 8
);
  // Handshake: a snapshot transfers on any rising edge where sample_valid and
  // sample_ready are both high. While valid is high and ready is low, the
  // producer holds data and flags constant. Ready may be raised before valid.
  logic             sample_valid;
  logic             sample_ready;
  logic [WIDTH-1:0] sample_data;
  logic             wrap_flag;
  logic             thresh_hit;
  logic             stab_err;

  modport master (
    output sample_valid,
    output sample_data,
    output wrap_flag,
    output thresh_hit,
    output stab_err,
    input  sample_ready
  );

  modport slave (
    input  sample_valid,
    input  sample_data,
    input  wrap_flag,
    input  thresh_hit,
    input  stab_err,
    output sample_ready
  );
endinterface

// File: rtl/ripple_count_sampler.sv
// Reads an asynchronous ripple counter through a two-deep sample pipe, waits for
// two matching samples (or gives up after MAX_RETRY tries) and offers a tagged snapshot.
module ripple_count_sampler #(
  parameter int WIDTH     = 8,
  parameter int MAX_RETRY = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       count_in,
  input  logic                   sample_req,
  input  logic [WIDTH-1:0]       threshold,
  ripple_count_sampler_if.master bus,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAMPLE  = 2'd1,
    PRESENT = 2'd2
  } state_t;

  localparam logic [3:0] RETRY_LAST = 4'(MAX_RETRY - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] samp_a, samp_b;
  logic [3:0]       retry_q, retry_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] last_acc_q, last_acc_d;
  logic             wrap_q, wrap_d;
  logic             hit_q, hit_d;
  logic             err_q, err_d;
  logic             stable;

  // Free-running pipe: two successive samples that agree mean the ripple has settled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      samp_a <= '0;
      samp_b <= '0;
    end else begin
      samp_a <= count_in;
      samp_b <= samp_a;
    end
  end

  assign stable = (samp_a == samp_b);

  always_comb begin
    state_d    = state_q;
    retry_d    = retry_q;
    valid_d    = valid_q;
    data_d     = data_q;
    last_acc_d = last_acc_q;
    wrap_d     = wrap_q;
    hit_d      = hit_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (sample_req) begin
          state_d = SAMPLE;
          retry_d = '0;
        end
      end
      SAMPLE: begin
        if (stable || (retry_q == RETRY_LAST)) begin
          data_d  = samp_a;
          err_d   = !stable;
          wrap_d  = (samp_a < last_acc_q);
          hit_d   = (samp_a >= threshold);
          state_d = PRESENT;
        end else begin
          retry_d = retry_q + 4'd1;
        end
      end
      PRESENT: begin
        // Valid rises one cycle after the load, so a snapshot is never offered
        // in the same cycle it is captured.
        if (!valid_q) begin
          valid_d = 1'b1;
        end else if (bus.sample_ready) begin
          valid_d    = 1'b0;
          last_acc_d = data_q;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      retry_q    <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      last_acc_q <= '0;
      wrap_q     <= 1'b0;
      hit_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      retry_q    <= retry_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      last_acc_q <= last_acc_d;
      wrap_q     <= wrap_d;
      hit_q      <= hit_d;
      err_q      <= err_d;
    end
  end

  assign bus.sample_valid = valid_q;
  assign bus.sample_data  = data_q;
  assign bus.wrap_flag    = wrap_q;
  assign bus.thresh_hit   = hit_q;
  assign bus.stab_err     = err_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_ripple_count_sampler.sv
// Bench for ripple_count_sampler: scenario tasks with randomized counts, checked
// against a history-based model of the two-sample stability rule.
module tb_ripple_count_sampler;
  localparam int WIDTH     = 8;
  localparam int MAX_RETRY = 4;
  localparam int HN        = 4096;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] count_in = 8'h00;
  logic       sample_req = 1'b0;
  logic [7:0] threshold = 8'h00;
  logic [1:0] dbg_state;

  ripple_count_sampler_if #(.WIDTH(WIDTH)) bus ();

  ripple_count_sampler #(.WIDTH(WIDTH), .MAX_RETRY(MAX_RETRY)) dut (
    .clk       (clk),
    .reset     (reset),
    .count_in  (count_in),
    .sample_req(sample_req),
    .threshold (threshold),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int         errors = 0;
  int         checks = 0;
  int         ec = 0;
  int         cnt_mode = 0;
  logic [7:0] last_acc_m = 8'h00;
  logic [7:0] hist_c [HN];
  logic [7:0] hist_t [HN];
  logic [7:0] exp_q [$];
  logic [11:0] obs;

  assign obs = {bus.sample_valid, bus.sample_data, bus.wrap_flag, bus.thresh_hit, bus.stab_err};

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Record what the DUT saw at every edge; ec is the index of the next edge.
  always @(posedge clk) begin
    hist_c[ec % HN] = count_in;
    hist_t[ec % HN] = threshold;
    ec = ec + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    case (cnt_mode)
      1: count_in = count_in ^ 8'($urandom_range(1, 255));
      2: if ($urandom_range(0, 2) == 0) count_in = 8'($urandom);
      default: ;
    endcase
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic hold_count(input logic [7:0] val);
    cnt_mode = 0;
    count_in = val;
    ticks(2);
  endtask

  task automatic capture(output int r, output int v, output bit ok);
    int n;
    sample_req = 1'b1;
    tick();
    r = ec - 1;
    sample_req = 1'b0;
    ok = 1'b0;
    v  = -1;
    n  = 0;
    while (!ok && n < 20) begin
      tick();
      n++;
      if (bus.sample_valid) begin
        ok = 1'b1;
        v  = ec - 1;
      end
    end
  endtask

  task automatic accept();
    bus.sample_ready = 1'b1;
    tick();
    bus.sample_ready = 1'b0;
  endtask

  // ---------------- reference model ----------------
  // Request taken at edge r. At decision edge e the block compares the counts it
  // saw at edges e-1 and e-2; it commits when they agree or on the last allowed try.
  function automatic void predict(input int r, output logic [7:0] d, output logic e_err,
                                  output logic e_hit, output int e_valid);
    int e;
    d = 8'h00; e_err = 1'b0; e_hit = 1'b0; e_valid = -1;
    for (int k = 1; k <= MAX_RETRY; k++) begin
      e = r + k;
      if (e_valid < 0 && (hist_c[(e-1) % HN] == hist_c[(e-2) % HN] || k == MAX_RETRY)) begin
        d       = hist_c[(e-1) % HN];
        e_err   = (hist_c[(e-1) % HN] != hist_c[(e-2) % HN]);
        e_hit   = (d >= hist_t[e % HN]);
        e_valid = e + 1;
      end
    end
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    bus.sample_ready = 1'b0;
    ticks(3);
    checks++;
    if (obs !== 12'h000) $display("FAIL reset_outputs: got %h expected %h", obs, 12'h000);
    checks++;
    if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d expected 0", dbg_state);
    reset = 1'b1;
    ticks(3);
    checks++;
    if (obs !== 12'h000) $display("FAIL post_reset_idle: got %h expected %h", obs, 12'h000);
    errors += (obs !== 12'h000) + (dbg_state !== 2'd0);
  endtask

  task automatic test_basic();
    int r;
    threshold = 8'h10;
    bus.sample_ready = 1'b1;
    hold_count(8'h2A);
    sample_req = 1'b1;
    tick();
    r = ec - 1;
    sample_req = 1'b0;
    tick();
    checks++;
    if (bus.sample_valid !== 1'b0) begin
      errors++; $display("FAIL basic_edge1_valid: got %b expected 0", bus.sample_valid);
    end
    tick();
    checks++;
    if (obs !== {1'b1, 8'h2A, 1'b0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL basic_edge2: got %h expected %h", obs, {1'b1, 8'h2A, 3'b010});
    end
    tick();
    checks++;
    if (bus.sample_valid !== 1'b0 || dbg_state !== 2'd0) begin
      errors++; $display("FAIL basic_edge3_idle: got valid=%b state=%0d expected valid=0 state=0",
                         bus.sample_valid, dbg_state);
    end
    last_acc_m = 8'h2A;
    bus.sample_ready = 1'b0;
    checks++;
    if (r + 2 != ec - 2) begin
      errors++; $display("FAIL basic_edge_count: got %0d expected %0d", ec - 2, r + 2);
    end
  endtask

  task automatic test_backpressure();
    int r, v, ev; bit ok; logic [7:0] d; logic e_err, e_hit; logic [11:0] exp;
    threshold = 8'($urandom);
    hold_count(8'($urandom));
    capture(r, v, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_timeout: got no valid expected valid"); end
    predict(r, d, e_err, e_hit, ev);
    exp = {1'b1, d, (d < last_acc_m), e_hit, e_err};
    checks++;
    if (v != ev) begin errors++; $display("FAIL bp_latency: got edge %0d expected %0d", v, ev); end
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL bp_first: got %h expected %h", obs, exp); end
    cnt_mode = 1;
    for (int i = 0; i < 5; i++) begin
      threshold = 8'($urandom);
      tick();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL bp_hold%0d: got %h expected %h", i, obs, exp); end
    end
    accept();
    checks++;
    if (bus.sample_valid !== 1'b0) begin
      errors++; $display("FAIL bp_transfer: got valid=%b expected 0", bus.sample_valid);
    end
    last_acc_m = d;
    cnt_mode = 0;
  endtask

  task automatic test_wrap();
    logic [7:0] vals [4];
    int r, v; bit ok; logic [11:0] exp;
    vals = '{8'hFE, 8'h03, 8'h07, 8'h07};
    threshold = 8'h00;
    foreach (vals[i]) begin
      hold_count(vals[i]);
      capture(r, v, ok);
      exp = {ok, vals[i], (vals[i] < last_acc_m), 1'b1, 1'b0};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL wrap%0d: got %h expected %h", i, obs, exp); end
      accept();
      last_acc_m = vals[i];
    end
  endtask

  task automatic test_threshold();
    logic [7:0] thr [6];
    logic [7:0] val [6];
    logic       hit [6];
    int r, v; bit ok;
    thr = '{8'd100, 8'd100, 8'd100, 8'd0, 8'd255, 8'd255};
    val = '{8'd99, 8'd100, 8'd255, 8'd0, 8'd254, 8'd255};
    hit = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    foreach (thr[i]) begin
      threshold = thr[i];
      hold_count(val[i]);
      capture(r, v, ok);
      checks++;
      if ({ok, bus.sample_data, bus.thresh_hit} !== {1'b1, val[i], hit[i]}) begin
        errors++; $display("FAIL thresh%0d: got data=%h hit=%b expected data=%h hit=%b",
                           i, bus.sample_data, bus.thresh_hit, val[i], hit[i]);
      end
      threshold = ~thr[i];
      tick();
      checks++;
      if (bus.thresh_hit !== hit[i]) begin
        errors++; $display("FAIL thresh_hold%0d: got %b expected %b", i, bus.thresh_hit, hit[i]);
      end
      accept();
      last_acc_m = val[i];
    end
  endtask

  task automatic test_instability();
    int r, v, ev; bit ok; logic [7:0] d; logic e_err, e_hit; logic [11:0] exp;
    threshold = 8'($urandom);
    cnt_mode = 1;
    ticks(3);
    capture(r, v, ok);
    predict(r, d, e_err, e_hit, ev);
    checks++;
    if (!ok || v != r + MAX_RETRY + 1) begin
      errors++; $display("FAIL unstable_latency: got edge %0d expected %0d", v - r, MAX_RETRY + 1);
    end
    exp = {1'b1, d, (d < last_acc_m), e_hit, 1'b1};
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL unstable_snap: got %h expected %h", obs, exp); end
    accept();
    last_acc_m = d;
    cnt_mode = 0;
  endtask

  task automatic test_back_to_back();
    int next_r, prev_v, v, ev, nsnap; logic [7:0] d; logic e_err, e_hit; logic [11:0] exp;
    cnt_mode = 2;
    threshold = 8'($urandom);
    bus.sample_ready = 1'b1;
    ticks(2);
    sample_req = 1'b1;
    next_r = ec;
    prev_v = -100;
    nsnap = 0;
    for (int i = 0; i < 60; i++) begin
      if (i == 40) sample_req = 1'b0;
      tick();
      if (bus.sample_valid) begin
        v = ec - 1;
        predict(next_r, d, e_err, e_hit, ev);
        exp = {1'b1, d, (d < last_acc_m), e_hit, e_err};
        checks++;
        if (v != ev) begin errors++; $display("FAIL b2b_latency: got edge %0d expected %0d", v, ev); end
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL b2b_snap: got %h expected %h", obs, exp); end
        checks++;
        if (v - prev_v < 3) begin errors++; $display("FAIL b2b_spacing: got %0d expected >=3", v - prev_v); end
        last_acc_m = d;
        prev_v = v;
        next_r = v + 2;
        nsnap++;
      end
    end
    checks++;
    if (nsnap < 5) begin errors++; $display("FAIL b2b_count: got %0d expected >=5", nsnap); end
    bus.sample_ready = 1'b0;
    cnt_mode = 0;
  endtask

  task automatic test_random();
    int r, v, ev, stall; bit ok, early; logic [7:0] d, got; logic e_err, e_hit; logic [11:0] exp;
    for (int it = 0; it < 20; it++) begin
      cnt_mode = $urandom_range(0, 2);
      threshold = 8'($urandom);
      count_in = 8'($urandom);
      early = 1'($urandom_range(0, 1));
      bus.sample_ready = early;
      ticks($urandom_range(0, 2));
      capture(r, v, ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL rand_timeout%0d: got no valid expected valid", it);
      end else begin
        predict(r, d, e_err, e_hit, ev);
        exp = {1'b1, d, (d < last_acc_m), e_hit, e_err};
        exp_q.push_back(d);
        checks++;
        if (v != ev || obs !== exp) begin
          errors++; $display("FAIL rand_snap%0d: got edge %0d %h expected edge %0d %h", it, v, obs, ev, exp);
        end
        if (!early) begin
          stall = $urandom_range(0, 3);
          repeat (stall) begin
            tick();
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL rand_hold%0d: got %h expected %h", it, obs, exp); end
          end
          bus.sample_ready = 1'b1;
        end
        tick();
        got = exp_q.pop_front();
        checks++;
        if (bus.sample_valid !== 1'b0 || bus.sample_data !== got) begin
          errors++; $display("FAIL rand_xfer%0d: got valid=%b data=%h expected valid=0 data=%h",
                             it, bus.sample_valid, bus.sample_data, got);
        end
        last_acc_m = got;
      end
      bus.sample_ready = 1'b0;
    end
    cnt_mode = 0;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rand_leftover: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int r, v; bit ok; int bad;
    threshold = 8'h00;
    hold_count(8'hC0);
    capture(r, v, ok);
    accept();
    // Reset while in SAMPLE.
    hold_count(8'h55);
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== 12'h000 || dbg_state !== 2'd0) begin
      errors++; $display("FAIL rst_sample: got %h state=%0d expected 000 state=0", obs, dbg_state);
    end
    reset = 1'b1;
    bad = 0;
    repeat (6) begin tick(); if (bus.sample_valid !== 1'b0) bad++; end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rst_sample_noval: got %0d valid cycles expected 0", bad); end
    // Reset while presenting.
    hold_count(8'h80);
    capture(r, v, ok);
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if (!ok || obs !== 12'h000) begin
      errors++; $display("FAIL rst_present: got ok=%b %h expected ok=1 000", ok, obs);
    end
    reset = 1'b1;
    bad = 0;
    repeat (6) begin tick(); if (bus.sample_valid !== 1'b0) bad++; end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rst_present_noval: got %0d valid cycles expected 0", bad); end
    last_acc_m = 8'h00;
    // First snapshot after reset compares against a cleared history.
    hold_count(8'h05);
    capture(r, v, ok);
    checks++;
    if (obs !== {1'b1, 8'h05, 1'b0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL rst_first_snap: got %h expected %h", obs, {1'b1, 8'h05, 3'b010});
    end
    accept();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_threshold();
    test_instability();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
